spi_xfer_ctrl: RTL and testbench

SPI master transfer controller. It accepts one word per command over a valid/ready interface and generates the SPI clock from its own half-period divider. It sequences chip-select, MOSI shifting and MISO sampling in SPI mode 0 (CPOL=0, CPHA=0), then returns the received word with a one-cycle response strobe. It sits between the AXI-lite register front end and the SPI pins, and replaces free-running clock generation with per-transfer sequenced clocking.

---
 rtl/spi_xfer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master: one word per command, sequenced CS/SCLK/MOSI/MISO.
// Define SPI_LSB_FIRST_EN for LSB-first shifting (default MSB-first).
module spi_xfer_ctrl #(
  parameter int FREQ_CLK   = 100000000,
  parameter int FREQ_SPI   = 2000000,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o
);

  localparam int HALF = FREQ_CLK / (2 * FREQ_SPI);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(DATA_WIDTH + 1);

  if (HALF < 2) begin : g_half_chk
    $error("spi_xfer_ctrl: HALF must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_dw_chk
    $error("spi_xfer_ctrl: DATA_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_e;

  state_e                state_q;
  logic [DW-1:0]         div_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] tx_d;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] rx_d;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  cs_n_q;
  logic                  rsp_valid_q;
  logic                  tick;
  logic                  first_bit;
  logic                  next_bit;

  assign tick  = (div_q == DW'(HALF - 1));
  assign cnt_d = cnt_q + 1'b1;

`ifdef SPI_LSB_FIRST_EN
  assign tx_d      = tx_q >> 1;
  assign rx_d      = (rx_q >> 1) |
                     (DATA_WIDTH'(miso_i) << (DATA_WIDTH - 1));
  assign first_bit = cmd_data_i[0];
  assign next_bit  = tx_d[0];
`else
  assign tx_d      = tx_q << 1;
  assign rx_d      = (rx_q << 1) | DATA_WIDTH'(miso_i);
  assign first_bit = cmd_data_i[DATA_WIDTH-1];
  assign next_bit  = tx_d[DATA_WIDTH-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (!en_i) begin
        // Abort or disabled idle: drop everything, no response.
        state_q <= IDLE;
        div_q   <= '0;
        sclk_q  <= 1'b0;
        mosi_q  <= 1'b0;
        cs_n_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            div_q <= '0;
            if (cmd_valid_i) begin
              tx_q    <= cmd_data_i;
              rx_q    <= '0;
              cnt_q   <= '0;
              mosi_q  <= first_bit;
              cs_n_q  <= 1'b0;
              state_q <= SETUP;
            end
          end
          SETUP: begin
            if (tick) begin
              div_q   <= '0;
              state_q <= XFER;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          XFER: begin
            if (tick) begin
              div_q  <= '0;
              sclk_q <= ~sclk_q;
              if (!sclk_q) begin
                rx_q <= rx_d;
              end else begin
                cnt_q <= cnt_d;
                if (cnt_d == CW'(DATA_WIDTH)) begin
                  state_q <= HOLD;
                end else begin
                  tx_q   <= tx_d;
                  mosi_q <= next_bit;
                end
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          HOLD: begin
            if (tick) begin
              div_q       <= '0;
              cs_n_q      <= 1'b1;
              mosi_q      <= 1'b0;
              rsp_data_q  <= rx_q;
              rsp_valid_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cmd_ready_o = !rst_i && en_i && (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign cs_n_o      = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a cycle-level SPI slave model.
// Randomized and directed transfers, abort, reset, backpressure, disable.
module tb_spi_xfer_ctrl;

  localparam int FC   = 100000000;
  localparam int FS   = 10000000;
  localparam int W    = 8;
  localparam int HALF = FC / (2 * FS);
  localparam int T    = 1 + (2 * W + 2) * HALF;
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         en_i = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic [W-1:0] cmd_data_i = '0;
  logic         miso_i;
  logic         cmd_ready_o;
  logic         rsp_valid_o;
  logic [W-1:0] rsp_data_o;
  logic         busy_o;
  logic         sclk_o;
  logic         mosi_o;
  logic         cs_n_o;

  spi_xfer_ctrl #(
    .FREQ_CLK  (FC),
    .FREQ_SPI  (FS),
    .DATA_WIDTH(W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_data_i (cmd_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .busy_o     (busy_o),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .cs_n_o     (cs_n_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Expected MOSI stream as captured MSB-of-capture-first.
  function automatic logic [W-1:0] stream(input logic [W-1:0] c);
    logic [W-1:0] s = '0;
    for (int i = 0; i < W; i++)
      s = {s[W-2:0], (LSB ? c[i] : c[W-1-i])};
    return s;
  endfunction

  typedef struct {
    logic [W-1:0] cmd;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cyc_q[$];

  // SPI slave: loads its word on CS fall, advances on each SCLK fall.
  logic [W-1:0] next_slave = '0;
  logic [W-1:0] sw = '0;
  int           idx = 0;
  bit           cs_act = 1'b0;
  logic         sclk_ps = 1'b0;

  assign miso_i = (!cs_n_o && idx < W) ? sw[LSB ? idx : W-1-idx] : 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (cs_n_o !== 1'b0) begin
      cs_act = 1'b0;
    end else if (!cs_act) begin
      cs_act = 1'b1;
      sw     = next_slave;
      idx    = 0;
    end else if (sclk_ps && !sclk_o) begin
      idx++;
    end
    sclk_ps = sclk_o;
  end

  // Monitor: pops expectations on each response strobe.
  int           rises = 0;
  int           last_fall = 0;
  logic [W-1:0] mcap = '0;
  logic [W-1:0] last_rsp = '0;
  logic         sclk_pm = 1'b0;
  logic         cs_pm = 1'b1;
  logic         rsp_pm = 1'b0;

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_i) begin
      rises    = 0;
      mcap     = '0;
      last_rsp = '0;
      sclk_pm  = 1'b0;
      cs_pm    = 1'b1;
      rsp_pm   = 1'b0;
    end else begin
      if (cs_pm && !cs_n_o) begin
        rises = 0;
        mcap  = '0;
      end
      if (sclk_o && !sclk_pm) begin
        rises++;
        mcap = {mcap[W-2:0], mosi_o};
        chk(cs_n_o == 1'b0, "cs_low_at_rise", cs_n_o, 0);
      end
      if (!sclk_o && sclk_pm) last_fall = cyc;
      if (rsp_valid_o) begin
        chk(!rsp_pm, "rsp_one_cycle", rsp_pm, 0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_rsp", rsp_data_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk(rsp_data_o == e.data, "rsp_data", rsp_data_o, e.data);
          chk(cyc == e.due, "rsp_cycle", cyc, e.due);
          chk(rises == W, "sclk_rises", rises, W);
          chk(mcap == stream(e.cmd), "mosi_stream", mcap, stream(e.cmd));
          chk(last_fall == e.due - HALF, "last_fall",
              last_fall, e.due - HALF);
          chk(cs_n_o == 1'b1, "cs_at_rsp", cs_n_o, 1);
          last_rsp = e.data;
          rsp_cyc_q.push_back(cyc);
        end
      end
      sclk_pm = sclk_o;
      cs_pm   = cs_n_o;
      rsp_pm  = rsp_valid_o;
    end
  end

  task automatic issue(input logic [W-1:0] d, input logic [W-1:0] sl,
                       input bit expect_rsp, output int k);
    int n = 0;
    bit rdy;
    exp_t e;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_data_i  = d;
    next_slave  = sl;
    k = -1;
    forever begin
      #1 rdy = cmd_ready_o;
      if (busy_o) chk(!rdy, "ready_while_busy", rdy, 0);
      @(posedge clk);
      #2;
      if (rdy) begin
        k = cyc;
        break;
      end
      n++;
      if (n > 400) begin
        chk(1'b0, "accept_timeout", n, 0);
        break;
      end
      @(negedge clk);
    end
    if (k >= 0) begin
      chk(cs_n_o == 1'b0, "cs_fall", cs_n_o, 0);
      chk(busy_o == 1'b1, "busy_after_accept", busy_o, 1);
      if (expect_rsp) begin
        e.cmd  = d;
        e.data = sl;
        e.due  = k + T - 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_data_i  = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    @(posedge clk);
    #3;
    while ((exp_q.size() != 0 || busy_o) && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk(n < 2000, "done_timeout", n, 0);
  endtask

  initial begin
    int k, k1, k2;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk(cmd_ready_o == 1'b0, "rst_ready", cmd_ready_o, 0);
    chk(cs_n_o == 1'b1, "rst_cs", cs_n_o, 1);
    chk(sclk_o == 1'b0, "rst_sclk", sclk_o, 0);
    chk(mosi_o == 1'b0, "rst_mosi", mosi_o, 0);
    chk(busy_o == 1'b0, "rst_busy", busy_o, 0);
    chk(rsp_valid_o == 1'b0, "rst_rsp_valid", rsp_valid_o, 0);
    chk(rsp_data_o == '0, "rst_rsp_data", rsp_data_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #2;
    chk(cmd_ready_o == 1'b1, "idle_ready", cmd_ready_o, 1);

    // Single transfer
    issue(8'hA5, 8'h3C, 1'b1, k);
    drop_valid();
    wait_done();

    // Back-to-back with valid held high
    rsp_cyc_q.delete();
    issue(8'h01, W'($urandom), 1'b1, k1);
    issue(8'hFF, W'($urandom), 1'b1, k2);
    drop_valid();
    wait_done();
    if (rsp_cyc_q.size() == 2) begin
      chk(k2 == rsp_cyc_q[0] + 1, "b2b_cs_gap", k2, rsp_cyc_q[0] + 1);
      chk(rsp_cyc_q[1] - rsp_cyc_q[0] == T, "b2b_period",
          rsp_cyc_q[1] - rsp_cyc_q[0], T);
    end else begin
      chk(1'b0, "b2b_rsp_count", rsp_cyc_q.size(), 2);
    end

    // Single-bit pattern
    issue(8'h01, 8'h01, 1'b1, k);
    drop_valid();
    wait_done();

    // Abort at cycle 40
    issue(W'($urandom), W'($urandom), 1'b0, k);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (39) @(negedge clk);
    en_i = 1'b0;
    @(posedge clk);
    #2;
    chk(cs_n_o == 1'b1, "abort_cs", cs_n_o, 1);
    chk(sclk_o == 1'b0, "abort_sclk", sclk_o, 0);
    chk(busy_o == 1'b0, "abort_busy", busy_o, 0);
    chk(rsp_valid_o == 1'b0, "abort_rsp_valid", rsp_valid_o, 0);
    chk(rsp_data_o == last_rsp, "abort_rsp_data", rsp_data_o, last_rsp);

    // Disabled idle ignores commands
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_data_i  = W'($urandom);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk(cmd_ready_o == 1'b0, "dis_ready", cmd_ready_o, 0);
      @(posedge clk);
      #2;
      chk(cs_n_o == 1'b1, "dis_cs", cs_n_o, 1);
      chk(busy_o == 1'b0, "dis_busy", busy_o, 0);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    en_i = 1'b1;
    repeat (100) @(negedge clk);
    chk(rsp_data_o == last_rsp, "abort_hold_data", rsp_data_o, last_rsp);

    // Reset mid-transfer, then a normal transfer
    issue(W'($urandom), W'($urandom), 1'b0, k);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (29) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #2;
    chk(cs_n_o == 1'b1, "mrst_cs", cs_n_o, 1);
    chk(sclk_o == 1'b0, "mrst_sclk", sclk_o, 0);
    chk(mosi_o == 1'b0, "mrst_mosi", mosi_o, 0);
    chk(busy_o == 1'b0, "mrst_busy", busy_o, 0);
    chk(cmd_ready_o == 1'b0, "mrst_ready", cmd_ready_o, 0);
    chk(rsp_valid_o == 1'b0, "mrst_rsp_valid", rsp_valid_o, 0);
    chk(rsp_data_o == '0, "mrst_rsp_data", rsp_data_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    issue(8'h5A, W'($urandom), 1'b1, k);
    drop_valid();
    wait_done();

    // Randomized traffic, some back-to-back
    for (int i = 0; i < 8; i++) begin
      issue(W'($urandom), W'($urandom), 1'b1, k);
      if ($urandom_range(0, 1) == 0) begin
        drop_valid();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    drop_valid();
    wait_done();

    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
